// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size encodings (2'b11 is illegal)
//   state_t                 : responder FSM states
//   req_t                   : request fields captured at the accepting edge
//   addr_w()                : word-index width, log2(DEPTH_WORDS)
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  function automatic int addr_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage, synchronous byte-enabled write,
// combinational read. Contents are never reset.
//   clk   : rising-edge clock
//   be    : per-byte write enables, lane 0 = bits [7:0]
//   addr  : word index (shared by read and write)
//   wdata : write data, already steered onto its lanes
//   rdata : word at addr
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (be[l]) mem[addr][l] <= wdata[8*l +: 8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store target for the core's memory stage.
// One request at a time: accept (IDLE), count WAIT_STATES, access, then hold
// the response (RESP) until rsp_ready.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault;
// without it they are silently forced to natural alignment.
//   clk, reset                   : clock, async active-low reset
//   req_valid/req_ready          : request handshake
//   req_we, req_addr, req_wdata,
//   req_size, req_unsigned       : request fields, sampled on acceptance
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata, rsp_err           : extended load data / fault flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = addr_w(DEPTH_WORDS);

  state_t          state, state_nx;
  logic [3:0]      cnt;
  req_t            req_q;
  logic            access;

  logic [1:0]      lane;
  logic            err;
  logic [3:0]      be;
  logic [3:0][7:0] lane_wdata;
  logic [31:0]     mem_rdata;
  logic [31:0]     shifted;
  logic [31:0]     load_data;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    access    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          access   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Capture and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
      cnt   <= '0;
    end else if (req_valid && req_ready) begin
      req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                 size: req_size, uns: req_unsigned};
      cnt   <= 4'(WAIT_STATES);
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // ---------------- access decode ----------------
  // Anything at or above DEPTH_WORDS*4 has a bit set above the word index.
  logic oob;
  assign oob = |(req_q.addr >> (ADDR_W + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (req_q.size == SZ_HALF && req_q.addr[0]) ||
                    (req_q.size == SZ_WORD && req_q.addr[1:0] != 2'b00);
  assign err  = (req_q.size == 2'b11) || oob || misalign;
  assign lane = req_q.addr[1:0];
`else
  assign err  = (req_q.size == 2'b11) || oob;
  assign lane = (req_q.size == SZ_HALF) ? {req_q.addr[1], 1'b0} :
                (req_q.size == SZ_WORD) ? 2'b00 : req_q.addr[1:0];
`endif

  // Per-lane store steering: byte data replicated to every lane, half data
  // to both halves; the enable picks the lane(s) actually written.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    always_comb begin
      be[l]         = 1'b0;
      lane_wdata[l] = req_q.wdata[8*l +: 8];
      case (req_q.size)
        SZ_BYTE: begin
          be[l]         = (lane == 2'(l));
          lane_wdata[l] = req_q.wdata[7:0];
        end
        SZ_HALF: begin
          be[l]         = (lane[1] == 1'(l >> 1));
          lane_wdata[l] = (l % 2 == 1) ? req_q.wdata[15:8] : req_q.wdata[7:0];
        end
        SZ_WORD: be[l] = 1'b1;
        default: be[l] = 1'b0;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .be    ((access && req_q.we && !err) ? be : 4'b0000),
    .addr  (req_q.addr[ADDR_W+1:2]),
    .wdata (lane_wdata),
    .rdata (mem_rdata)
  );

  // Load extraction: shift the addressed lane down, then extend.
  assign shifted = mem_rdata >> {lane, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (req_q.size)
      SZ_BYTE: load_data = req_q.uns ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = req_q.uns ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Response registers, loaded once at the access edge and held in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= err;
      rsp_rdata <= (err || req_q.we) ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven check of dmem_responder (DEPTH_WORDS=1024,
// WAIT_STATES=2) plus hand-written sequences for back-pressure, reset abort
// in WAIT, reset in RESP and stray rsp_ready while idle.
module tb_dmem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz, input logic u,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = nm; v.we = we; v.addr = a; v.wdata = d; v.size = sz; v.uns = u;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request and let it be accepted; afterwards the request pins are
  // scrambled so a design that re-samples them would misbehave.
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic u);
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = ~u;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input string nm);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, " idle req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_req(v.we, v.addr, v.wdata, v.size, v.uns);
    wait_rsp(lat);
    chk({v.name, " latency"}, 32'(lat), 32'(WS + 1));
    chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
    finish_rsp(v.name);
  endtask

  initial begin
    logic [31:0] held_data;
    logic        held_err;
    int          lat;
    int          seen;

    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;

    // vectors: name, we, addr, wdata, size, uns, exp_rdata, exp_err
    add("st_w_10",    1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
    add("ld_w_10",    0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
    add("st_b_13",    1, 32'h13,   32'hFFFFFF80, 2'b00, 0, 32'h0, 0);
    add("ld_bs_13",   0, 32'h13,   32'h0,        2'b00, 0, 32'hFFFFFF80, 0);
    add("ld_bu_13",   0, 32'h13,   32'h0,        2'b00, 1, 32'h00000080, 0);
    add("ld_w_10b",   0, 32'h10,   32'h0,        2'b10, 0, 32'h80ADBEEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add("ld_h_11",    0, 32'h11,   32'h0,        2'b01, 0, 32'h0, 1);
`else
    add("ld_h_11",    0, 32'h11,   32'h0,        2'b01, 0, 32'hFFFFBEEF, 0);
`endif
    add("st_w_0",     1, 32'h0,    32'h0BADF00D, 2'b10, 0, 32'h0, 0);
    add("st_oob",     1, 32'h1000, 32'hCAFEF00D, 2'b10, 0, 32'h0, 1);
    add("ld_w_0",     0, 32'h0,    32'h0,        2'b10, 0, 32'h0BADF00D, 0);
    add("ld_oob",     0, 32'h1000, 32'h0,        2'b10, 0, 32'h0, 1);
    add("st_sz3",     1, 32'h10,   32'h11111111, 2'b11, 0, 32'h0, 1);
    add("ld_sz3",     0, 32'h10,   32'h0,        2'b11, 0, 32'h0, 1);
    add("ld_w_10c",   0, 32'h10,   32'h0,        2'b10, 0, 32'h80ADBEEF, 0);
    add("st_w_20",    1, 32'h20,   32'h11223344, 2'b10, 0, 32'h0, 0);
    add("st_h_22",    1, 32'h22,   32'hAAAA5555, 2'b01, 0, 32'h0, 0);
    add("ld_hu_22",   0, 32'h22,   32'h0,        2'b01, 1, 32'h00005555, 0);
    add("ld_hs_20",   0, 32'h20,   32'h0,        2'b01, 0, 32'h00003344, 0);
    add("ld_bs_21",   0, 32'h21,   32'h0,        2'b00, 0, 32'h00000033, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add("ld_w_22",    0, 32'h22,   32'h0,        2'b10, 0, 32'h0, 1);
`else
    add("ld_w_22",    0, 32'h22,   32'h0,        2'b10, 0, 32'h55553344, 0);
`endif
    add("st_b_fff",   1, 32'hFFF,  32'h000000A5, 2'b00, 0, 32'h0, 0);
    add("ld_bs_fff",  0, 32'hFFF,  32'h0,        2'b00, 0, 32'hFFFFFFA5, 0);
    add("ld_w_ffc",   0, 32'hFFC,  32'h0,        2'b10, 1, {8'hA5, 24'h0} | 32'h0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Word 0xFFC is only partly written (byte 3); mask the rest when checking.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].name == "ld_w_ffc") begin
        int l2;
        start_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns);
        wait_rsp(l2);
        chk("ld_w_ffc latency", 32'(l2), 32'(WS + 1));
        chk("ld_w_ffc top byte", rsp_rdata & 32'hFF000000, vecs[i].exp_rdata);
        chk("ld_w_ffc err", 32'(rsp_err), 32'd0);
        finish_rsp("ld_w_ffc");
      end else begin
        run_vec(vecs[i]);
      end
    end

    // Back-pressure: response held stable for 5 cycles with rsp_ready low.
    start_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    wait_rsp(lat);
    chk("hold latency", 32'(lat), 32'(WS + 1));
    chk("hold rdata", rsp_rdata, 32'h80ADBEEF);
    held_data = rsp_rdata;
    held_err  = rsp_err;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold rdata stable", rsp_rdata, held_data);
      chk("hold err stable", 32'(rsp_err), 32'(held_err));
      chk("hold req_ready", 32'(req_ready), 32'd0);
    end
    finish_rsp("hold");

    // rsp_ready while idle does nothing.
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stray rsp_ready valid", 32'(rsp_valid), 32'd0);
      chk("stray rsp_ready idle", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during WAIT aborts a store to 0x20. rsp_rdata currently holds
    // 0x80ADBEEF, so the reset-to-zero check is meaningful.
    start_req(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort rsp_rdata", rsp_rdata, 32'h0);
    chk("abort rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("abort no response", 32'(seen), 32'd0);
    run_vec('{name: "ld_w_20_after_abort", we: 1'b0, addr: 32'h20, wdata: 32'h0,
              size: 2'b10, uns: 1'b0, exp_rdata: 32'h55553344, exp_err: 1'b0});

    // Reset while in RESP drops rsp_valid at once.
    start_req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    wait_rsp(lat);
    chk("resp-reset pre valid", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("resp-reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("resp-reset req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    run_vec('{name: "ld_w_0_after_reset", we: 1'b0, addr: 32'h0, wdata: 32'h0,
              size: 2'b10, uns: 1'b0, exp_rdata: 32'h0BADF00D, exp_err: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage RISC-V core: the target side of the load/store interface driven by the memory stage. It accepts one load or store request at a time over a valid/ready handshake. It performs byte, halfword or word access with lane merging on stores and sign/zero extension on loads. After a fixed, parameterised number of wait states it returns a response over a second valid/ready handshake. The memory stage stalls on `req_ready`/`rsp_valid`, which lets the pipeline be exercised against multi-cycle memory.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 2: extra cycles between request acceptance and memory access; 0–15.
- Clock and reset: reset is `reset`, asynchronous, active-low; clock is `clk`.
- `clk`  input  1  clock, rising-edge.
- `reset`  input  1  asynchronous active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  responder idle and able to accept.
- `req_we`  input  1  1 = store, 0 = load.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`  input  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  input  1  load zero-extends when 1, sign-extends when 0.
- `rsp_valid`  output  1  response present.
- `rsp_ready`  input  1  consumer takes response.
- `rsp_rdata`  output  32  extended load data; 0 for stores and errors.
- `rsp_err`  output  1  access faulted; no memory state changed.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready` the block captures all req_* fields, loads the wait counter with `WAIT_STATES`, and goes to WAIT.
- WAIT: if counter == 0, perform the access and go to RESP; otherwise decrement the counter.
- Access, in priority order:
  - err if size==11;
  - err if `addr >= DEPTH_WORDS*4`;
  - err if misaligned, when the macro is enabled (see Configuration).
- On err: no write; `rsp_rdata`=0.
- Load: word index `addr[log2(DEPTH_WORDS)+1:2]`, lane `addr[1:0]`. Extract the byte or half, then extend to 32 bits per `req_unsigned`. Size 10 returns the full word.
- Store: write only the byte-enabled lanes; other lanes are unchanged. `rsp_rdata`=0.
- RESP: `rsp_valid`=1, with data and err held stable until `rsp_ready`. On `rsp_valid && rsp_ready` the block returns to IDLE. A new request is accepted no earlier than the following cycle.
- Memory array contents are not reset. Reset affects only the FSM, counter, captured fields and outputs.

## Timing
- Reset values of the outputs:
  - `req_ready`=1 (IDLE);
  - `rsp_valid`=0;
  - `rsp_rdata`=0;
  - `rsp_err`=0.
- Latency: with the accepting edge as E0, the access happens and `rsp_valid` rises at edge E0+WAIT_STATES+1. With `WAIT_STATES`=0 this is the next edge.
- `req_ready` is 0 in WAIT and RESP. Throughput is one transaction per WAIT_STATES+3 cycles when `rsp_ready` is held high.
- Request inputs are sampled only at the accepting edge. Later changes to them are ignored.
- Reset asserted in WAIT aborts the transaction: no store is committed and no response is issued.
- Reset asserted in RESP drops `rsp_valid` immediately. The store has already been committed.
- `rsp_ready` asserted while not in RESP has no effect.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - a half access with `addr[0]`≠0 returns `rsp_err`=1 with no write;
  - a word access with `addr[1:0]`≠0 returns `rsp_err`=1 with no write.
- Not defined: misaligned addresses are forced down to natural alignment (half clears bit 0, word clears bits 1:0). The access proceeds normally with no error.

## Structure
- Package `dmem_pkg` holds:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the FSM state enumeration;
  - the `ADDR_W = log2(DEPTH_WORDS)` helper.
- Sub-module `dmem_array`: synchronous-write, combinational-read storage with a 4-bit byte-enable write port.
- The FSM, lane steering and extension live in `dmem_responder`.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load a word from 0x10 with `WAIT_STATES`=2 → `rsp_valid` at E0+3, rdata 0xDEADBEEF, err 0.
- Store byte 0x80 to 0x13, then load signed byte from 0x13 → 0xFFFFFF80. Load unsigned byte from 0x13 → 0x00000080. Load word from 0x10 → 0x80ADBEEF.
- Load half from 0x11 with the macro defined → err 1, rdata 0. Without the macro → rdata 0xFFFFBEEF from 0x10.
- Store to 0x1000 with `DEPTH_WORDS`=1024 → err 1, and a subsequent word load from 0x0 is unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, data and err stay stable and `req_ready` stays 0. Raise `rsp_ready` → IDLE on the next edge.
- Issue a store of 0x12345678 to 0x20 and assert reset during WAIT → outputs at reset values, a word load from 0x20 returns the prior value, and no response is issued for the aborted request.
